display_scan_ctrl: RTL and testbench



---
 rtl/display_scan_ctrl_if.sv | 20 ++
 rtl/display_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_display_scan_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_if.sv
// Scan-controller bus: enable/mask (and optional dim) in, mux select, anodes and frame pulse out.
// Optional SCAN_DIM_EN adds the 2-bit dim control.
interface display_scan_ctrl_if;
    logic       enable;
    logic [3:0] digit_mask;
`ifdef SCAN_DIM_EN
    logic [1:0] dim;
`endif
    logic [1:0] sel;
    logic [3:0] digit_an;
    logic       frame_tick;

`ifdef SCAN_DIM_EN
    modport master (output enable, digit_mask, dim, input sel, digit_an, frame_tick);
    modport slave  (input enable, digit_mask, dim, output sel, digit_an, frame_tick);
`else
    modport master (output enable, digit_mask, input sel, digit_an, frame_tick);
    modport slave  (input enable, digit_mask, output sel, digit_an, frame_tick);
`endif
endinterface

// File: rtl/display_scan_ctrl.sv
// 4-digit seven-segment scan scheduler: rotates enabled digits with blanking gaps and a frame pulse.
// Optional SCAN_DIM_EN: per-slot anode on-time shortened by the 2-bit dim input.
module display_scan_ctrl #(
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                 clk,
    input  logic                 reset,
    display_scan_ctrl_if.slave   scan
);
    localparam int unsigned BLANK_EFF = (BLANK_CYCLES > 0) ? BLANK_CYCLES : 1;
    localparam int unsigned MAX_LEN   = (CLK_DIV > BLANK_EFF) ? CLK_DIV : BLANK_EFF;
    localparam int unsigned CNT_W     = $clog2(MAX_LEN) + 1;
    localparam int unsigned PROD_W    = CNT_W + 2;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_EFF - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       an_q, an_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] on_time;
    logic [CNT_W-1:0] on_new;
    logic [3:0]       an_lit;
    logic [1:0]       nxt;

    // First set mask bit strictly after cur, circularly, with cur itself checked last.
    function automatic logic [1:0] next_digit(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] r;
        logic [1:0] idx;
        logic       found;
        r     = cur;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + 2'(k);
            if (!found && m[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction

`ifdef SCAN_DIM_EN
    logic [CNT_W-1:0] on_time_q, on_time_d;
    logic [PROD_W-1:0] on_prod;

    always_comb begin
        on_prod = PROD_W'(CLK_DIV) * PROD_W'(3'd4 - {1'b0, scan.dim});
        on_new  = CNT_W'(on_prod >> 2);
    end
    assign on_time = on_time_q;
`else
    assign on_new  = CNT_W'(CLK_DIV);
    assign on_time = CNT_W'(CLK_DIV);
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        an_d    = 4'b1111;
        tick_d  = 1'b0;
        an_lit  = ~(4'b0001 << sel_q);
        nxt     = next_digit(sel_q, scan.digit_mask);
`ifdef SCAN_DIM_EN
        on_time_d = on_time_q;
`endif
        if (!scan.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scan.digit_mask != 4'b0000) begin
                        state_d = BLANK;
                        sel_d   = next_digit(2'd3, scan.digit_mask);
                        cnt_d   = '0;
                    end
                end
                BLANK: begin
                    if (scan.digit_mask == 4'b0000) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
`ifdef SCAN_DIM_EN
                        on_time_d = on_new;
`endif
                        an_d    = (on_new != '0) ? an_lit : 4'b1111;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d = '0;
                        if (scan.digit_mask == 4'b0000) begin
                            state_d = IDLE;
                        end else begin
                            state_d = BLANK;
                            sel_d   = nxt;
                            tick_d  = (nxt <= sel_q);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        an_d  = ((cnt_q + CNT_W'(1)) < on_time) ? an_lit : 4'b1111;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= 2'b00;
            an_q    <= 4'b1111;
            tick_q  <= 1'b0;
`ifdef SCAN_DIM_EN
            on_time_q <= CNT_W'(CLK_DIV);
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            tick_q  <= tick_d;
`ifdef SCAN_DIM_EN
            on_time_q <= on_time_d;
`endif
        end
    end

    assign scan.sel        = sel_q;
    assign scan.digit_an   = an_q;
    assign scan.frame_tick = tick_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with CLK_DIV=4, BLANK_CYCLES=2 (6-cycle digit slots).
// Define SCAN_DIM_EN to also exercise the dimming path.
module tb_display_scan_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    display_scan_ctrl_if scan_bus ();

    display_scan_ctrl #(.CLK_DIV(4), .BLANK_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .scan  (scan_bus)
    );

    always #5 clk = ~clk;

    logic [3:0] rot_masks [3] = '{4'b1111, 4'b0101, 4'b1000};
    logic [1:0] rot_seqs  [3][4] = '{'{2'd0, 2'd1, 2'd2, 2'd3},
                                     '{2'd0, 2'd2, 2'd0, 2'd2},
                                     '{2'd3, 2'd3, 2'd3, 2'd3}};
    // {sel, digit_an, frame_tick} per cycle for the mask-change scenario
    logic [6:0] mc_exp [14] = '{7'b00_1111_0, 7'b00_1111_0, 7'b00_1110_0, 7'b00_1110_0,
                                7'b00_1110_0, 7'b00_1110_0, 7'b00_1111_1, 7'b00_1111_0,
                                7'b00_1110_0, 7'b00_1110_0, 7'b00_1110_0, 7'b00_1110_0,
                                7'b00_1111_0, 7'b00_1111_0};

    task automatic test_reset();
        reset = 1'b1;
        scan_bus.enable = 1'b1;
        scan_bus.digit_mask = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if ({scan_bus.sel, scan_bus.digit_an, scan_bus.frame_tick} !== 7'b00_1111_0) begin
                fails++;
                $display("FAIL reset_held c=%0d: got sel=%0d an=%b tick=%b, want sel=0 an=1111 tick=0",
                         c, scan_bus.sel, scan_bus.digit_an, scan_bus.frame_tick);
            end
        end
        reset = 1'b0;
        scan_bus.enable = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            tests++;
            if ({scan_bus.sel, scan_bus.digit_an, scan_bus.frame_tick} !== 7'b00_1111_0) begin
                fails++;
                $display("FAIL reset_idle c=%0d: got sel=%0d an=%b tick=%b, want sel=0 an=1111 tick=0",
                         c, scan_bus.sel, scan_bus.digit_an, scan_bus.frame_tick);
            end
        end
    endtask

    task automatic test_rotation();
        logic [1:0] es;
        logic [3:0] ea;
        logic       et;
        int         j, off;
        for (int p = 0; p < 3; p++) begin
            scan_bus.enable = 1'b0;
            @(negedge clk);
            @(negedge clk);
            scan_bus.digit_mask = rot_masks[p];
            scan_bus.enable = 1'b1;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                j   = c / 6;
                off = c % 6;
                es  = rot_seqs[p][j % 4];
                ea  = (off >= 2) ? (4'b1111 ^ (4'b0001 << es)) : 4'b1111;
                et  = (off == 0) && (j > 0) && (es <= rot_seqs[p][(j - 1) % 4]);
                tests++;
                if ({scan_bus.sel, scan_bus.digit_an, scan_bus.frame_tick} !== {es, ea, et}) begin
                    fails++;
                    $display("FAIL rotation mask=%b c=%0d: got sel=%0d an=%b tick=%b, want sel=%0d an=%b tick=%b",
                             rot_masks[p], c, scan_bus.sel, scan_bus.digit_an, scan_bus.frame_tick, es, ea, et);
                end
            end
            scan_bus.enable = 1'b0;
            @(negedge clk);
            es = rot_seqs[p][0];
            tests++;
            if ({scan_bus.sel, scan_bus.digit_an, scan_bus.frame_tick} !== {es, 4'b1111, 1'b0}) begin
                fails++;
                $display("FAIL rotation_stop mask=%b: got sel=%0d an=%b tick=%b, want sel=%0d an=1111 tick=0",
                         rot_masks[p], scan_bus.sel, scan_bus.digit_an, scan_bus.frame_tick, es);
            end
        end
    endtask

    task automatic test_enable_drop();
        logic [1:0] es;
        logic [3:0] ea;
        int         off;
        scan_bus.digit_mask = 4'b1111;
        scan_bus.enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            es  = 2'(c / 6);
            off = c % 6;
            ea  = (off >= 2) ? (4'b1111 ^ (4'b0001 << es)) : 4'b1111;
            tests++;
            if ({scan_bus.sel, scan_bus.digit_an} !== {es, ea}) begin
                fails++;
                $display("FAIL drop_run c=%0d: got sel=%0d an=%b, want sel=%0d an=%b",
                         c, scan_bus.sel, scan_bus.digit_an, es, ea);
            end
        end
        scan_bus.enable = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests++;
            if ({scan_bus.sel, scan_bus.digit_an, scan_bus.frame_tick} !== 7'b01_1111_0) begin
                fails++;
                $display("FAIL drop_dark c=%0d: got sel=%0d an=%b tick=%b, want sel=1 an=1111 tick=0",
                         c, scan_bus.sel, scan_bus.digit_an, scan_bus.frame_tick);
            end
        end
        scan_bus.enable = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            es  = 2'(c / 6);
            off = c % 6;
            ea  = (off >= 2) ? (4'b1111 ^ (4'b0001 << es)) : 4'b1111;
            tests++;
            if ({scan_bus.sel, scan_bus.digit_an} !== {es, ea}) begin
                fails++;
                $display("FAIL reenable c=%0d: got sel=%0d an=%b, want sel=%0d an=%b",
                         c, scan_bus.sel, scan_bus.digit_an, es, ea);
            end
        end
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests++;
            if ({scan_bus.sel, scan_bus.digit_an, scan_bus.frame_tick} !== 7'b00_1111_0) begin
                fails++;
                $display("FAIL midscan_reset c=%0d: got sel=%0d an=%b tick=%b, want sel=0 an=1111 tick=0",
                         c, scan_bus.sel, scan_bus.digit_an, scan_bus.frame_tick);
            end
        end
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            ea = (c == 2) ? 4'b1110 : 4'b1111;
            tests++;
            if ({scan_bus.sel, scan_bus.digit_an} !== {2'b00, ea}) begin
                fails++;
                $display("FAIL post_reset c=%0d: got sel=%0d an=%b, want sel=0 an=%b",
                         c, scan_bus.sel, scan_bus.digit_an, ea);
            end
        end
        scan_bus.enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mask_change();
        scan_bus.digit_mask = 4'b0011;
        scan_bus.enable = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            tests++;
            if ({scan_bus.sel, scan_bus.digit_an, scan_bus.frame_tick} !== mc_exp[c]) begin
                fails++;
                $display("FAIL mask_change c=%0d: got %b, want %b (sel,an,tick)",
                         c, {scan_bus.sel, scan_bus.digit_an, scan_bus.frame_tick}, mc_exp[c]);
            end
            if (c == 3) scan_bus.digit_mask = 4'b0001;
            if (c == 8) scan_bus.digit_mask = 4'b0000;
        end
        // Mask cleared while blanking goes straight back to idle.
        scan_bus.digit_mask = 4'b0010;
        @(negedge clk);
        tests++;
        if ({scan_bus.sel, scan_bus.digit_an} !== 6'b01_1111) begin
            fails++;
            $display("FAIL blank_enter: got sel=%0d an=%b, want sel=1 an=1111", scan_bus.sel, scan_bus.digit_an);
        end
        scan_bus.digit_mask = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if ({scan_bus.sel, scan_bus.digit_an, scan_bus.frame_tick} !== 7'b01_1111_0) begin
                fails++;
                $display("FAIL blank_zero c=%0d: got sel=%0d an=%b tick=%b, want sel=1 an=1111 tick=0",
                         c, scan_bus.sel, scan_bus.digit_an, scan_bus.frame_tick);
            end
        end
        scan_bus.enable = 1'b0;
        @(negedge clk);
    endtask

`ifdef SCAN_DIM_EN
    task automatic test_dim();
        logic [3:0] ea;
        int         off;
        for (int d = 2; d <= 3; d++) begin
            scan_bus.enable = 1'b0;
            @(negedge clk);
            scan_bus.dim = 2'(d);
            scan_bus.digit_mask = 4'b0001;
            scan_bus.enable = 1'b1;
            for (int c = 0; c < 18; c++) begin
                @(negedge clk);
                off = c % 6;
                ea  = ((off >= 2) && (off < 2 + (4 - d))) ? 4'b1110 : 4'b1111;
                tests++;
                if (scan_bus.digit_an !== ea) begin
                    fails++;
                    $display("FAIL dim=%0d c=%0d: got an=%b, want an=%b", d, c, scan_bus.digit_an, ea);
                end
            end
        end
        scan_bus.enable = 1'b0;
        scan_bus.dim = 2'd0;
        @(negedge clk);
    endtask
`endif

    initial begin
        scan_bus.enable = 1'b0;
        scan_bus.digit_mask = 4'b0000;
`ifdef SCAN_DIM_EN
        scan_bus.dim = 2'd0;
`endif
        test_reset();
        test_rotation();
        test_enable_drop();
        test_mask_change();
`ifdef SCAN_DIM_EN
        test_dim();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
